// File: rtl/mpu_pkg.sv
// Shared constants, opcodes and state encoding
// for the 5x5 matrix-processing sequencer.
package mpu_pkg;

  localparam int DATA_W = 8;
  localparam int DIM    = 5;
  localparam int N      = DIM * DIM;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_OPP   = 3'd2;
  localparam logic [2:0] OP_TRANS = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_EXEC,
    ST_DRAIN
  } state_t;

  // Bit offset of element (row, col) in a row-major flat matrix
  function automatic int elem_off(input int row, input int col);
    return DATA_W * (row * DIM + col);
  endfunction

endpackage

// File: rtl/mpu_alu.sv
// Whole-matrix combinational operation unit:
// element-wise add/sub/negate/scale and transpose.
module mpu_alu
  import mpu_pkg::*;
(
  input  logic [N*DATA_W-1:0] a,
  input  logic [N*DATA_W-1:0] b,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   scalar,
  output logic [N*DATA_W-1:0] res
);

  function automatic logic [DATA_W-1:0] calc(
    input logic [2:0]        f,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic [DATA_W-1:0] t,
    input logic [DATA_W-1:0] s
  );
    logic signed [2*DATA_W-1:0] p;
    p = $signed(x) * $signed(s);
    unique case (f)
      OP_ADD:   return x + y;
      OP_SUB:   return x - y;
      OP_OPP:   return '0 - x;
      OP_TRANS: return t;
      OP_SCALE: return p[DATA_W-1:0];
      default:  return '0;
    endcase
  endfunction

  // Evaluate every element; t is the mirrored element of a
  always_comb begin
    res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        res[elem_off(r, c) +: DATA_W] = calc(
          op,
          a[elem_off(r, c) +: DATA_W],
          b[elem_off(r, c) +: DATA_W],
          a[elem_off(c, r) +: DATA_W],
          scalar);
      end
    end
  end

endmodule

// File: rtl/mpu_op_sequencer.sv
// Command/load/exec/drain controller around the
// combinational matrix unit, with valid/ready streams.
module mpu_op_sequencer
  import mpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_scalar,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              error
);

  state_t              state;
  logic [4:0]          cnt;
  logic [2:0]          op;
  logic [DATA_W-1:0]   scalar;
  logic [N*DATA_W-1:0] a;
  logic [N*DATA_W-1:0] b;
  logic [N*DATA_W-1:0] res;
  logic [N*DATA_W-1:0] alu_res;
  logic                in_fire;
  logic                out_fire;
  logic                last_idx;
  logic                two_op;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_idx = (cnt == 5'(N - 1));
  assign two_op   = (op == OP_ADD) || (op == OP_SUB);

  mpu_alu u_alu (
    .a      (a),
    .b      (b),
    .op     (op),
    .scalar (scalar),
    .res    (alu_res)
  );

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op        <= '0;
      scalar    <= '0;
      a         <= '0;
      b         <= '0;
      res       <= '0;
      cmd_ready <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op     <= cmd_op;
            scalar <= cmd_scalar;
            if (cmd_op <= OP_SCALE) begin
              state     <= ST_LOAD_A;
              cnt       <= '0;
              cmd_ready <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          if (in_fire) begin
            a[int'(cnt)*DATA_W +: DATA_W] <= in_data;
            if (last_idx) begin
              cnt <= '0;
              if (two_op) begin
                state <= ST_LOAD_B;
              end else begin
                state    <= ST_EXEC;
                in_ready <= 1'b0;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_LOAD_B: begin
          if (in_fire) begin
            b[int'(cnt)*DATA_W +: DATA_W] <= in_data;
            if (last_idx) begin
              cnt      <= '0;
              state    <= ST_EXEC;
              in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_EXEC: begin
          res       <= alu_res;
          out_data  <= alu_res[DATA_W-1:0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          cnt       <= '0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (last_idx) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              cnt      <= cnt + 5'd1;
              out_data <= res[(int'(cnt)+1)*DATA_W +: DATA_W];
              out_last <= (cnt == 5'(N - 2));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_op_sequencer.sv
// Randomised bench for mpu_op_sequencer with an
// array-based reference model of the matrix operations.
module tb_mpu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_scalar;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       error;

  int vec = 0;
  int bad = 0;

  logic [7:0] ma[25];
  logic [7:0] mb[25];
  logic [7:0] ex[25];
  logic [7:0] gd[$];
  logic       gl[$];
  int         stall_err;
  int         lat_first;
  bit         tmo;

  always #5 clk = ~clk;

  mpu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_scalar (cmd_scalar),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .error      (error)
  );

  // Reference: plain signed integer arithmetic, wrapped to 8 bits
  function automatic void model(input logic [2:0] op,
                                input logic [7:0] sc);
    int av, bv, sv, r, c;
    for (int i = 0; i < 25; i++) begin
      av = $signed(ma[i]);
      bv = $signed(mb[i]);
      sv = $signed(sc);
      r = i / 5;
      c = i % 5;
      case (op)
        3'd0: ex[i] = 8'(av + bv);
        3'd1: ex[i] = 8'(av - bv);
        3'd2: ex[i] = 8'(-av);
        3'd3: ex[i] = ma[c * 5 + r];
        default: ex[i] = 8'(av * sv);
      endcase
    end
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 25; i++) begin
      ma[i] = 8'($urandom);
      mb[i] = 8'($urandom);
    end
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 25; i++) begin
      ma[i] = 8'(i + 1);
      mb[i] = 8'd127;
    end
  endtask

  // Host agent: issue command, stream operands, collect results
  task automatic run_txn(input logic [2:0] op,
                         input logic [7:0] sc,
                         input bit gaps,
                         input bit bp,
                         input int abort_at);
    int idx, total, budget, lat;
    logic [7:0] pd;
    logic pl;
    bit pstall;
    gd.delete();
    gl.delete();
    stall_err = 0;
    lat_first = 0;
    tmo = 0;
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      tmo = 1;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_scalar = sc;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    total = (op == 3'd0 || op == 3'd1) ? 50 : 25;
    idx = 0;
    budget = 0;
    while (idx < total && budget < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = (idx < 25) ? ma[idx] : mb[idx - 25];
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      lat++;
      budget++;
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    pstall = 0;
    pd = '0;
    pl = 0;
    while (gd.size() < 25 && budget < 2000) begin
      if (out_valid && lat_first == 0) lat_first = lat;
      if (out_valid && pstall &&
          (out_data !== pd || out_last !== pl))
        stall_err++;
      out_ready = bp ? ~out_ready : 1'b1;
      if (out_valid && out_ready) begin
        gd.push_back(out_data);
        gl.push_back(out_last);
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (abort_at > 0 && gd.size() == abort_at) return;
      @(negedge clk);
      lat++;
      budget++;
    end
    if (budget >= 2000) tmo = 1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vec++;
    if ({cmd_ready, in_ready, out_valid, out_last,
         busy, error, out_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
        {cmd_ready, in_ready, out_valid, out_last,
         busy, error, out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_opp();
    fill_seq();
    model(3'd2, 8'h00);
    run_txn(3'd2, 8'h00, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25) begin
      bad++;
      $display("FAIL opp_done got=%0d exp=25", gd.size());
      return;
    end
    for (int i = 0; i < 25; i++) begin
      vec++;
      if (gd[i] !== ex[i] || gl[i] !== (i == 24)) begin
        bad++;
        $display("FAIL opp_beat%0d got=%h/%b exp=%h/%b",
          i, gd[i], gl[i], ex[i], i == 24);
      end
    end
    vec++;
    if (gd[0] !== 8'hFF || gd[24] !== 8'hE7) begin
      bad++;
      $display("FAIL opp_ends got=%h,%h exp=ff,e7", gd[0], gd[24]);
    end
    vec++;
    if (lat_first != 27) begin
      bad++;
      $display("FAIL opp_latency got=%0d exp=27", lat_first);
    end
    vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        cmd_ready !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL opp_idle got=%b%b%b%b exp=0010",
        out_valid, busy, cmd_ready, error);
    end
  endtask

  task automatic test_add_sub();
    fill_seq();
    model(3'd0, 8'h00);
    run_txn(3'd0, 8'h00, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25 || gd[0] !== 8'h80 ||
        gd[1] !== 8'h81 || gd[24] !== 8'h98) begin
      bad++;
      $display("FAIL add_wrap got=%0d beats exp=25 80,81,98",
        gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      vec++;
      if (gd[i] !== ex[i]) begin
        bad++;
        $display("FAIL add_beat%0d got=%h exp=%h", i, gd[i], ex[i]);
      end
    end
    fill_rand();
    for (int i = 0; i < 25; i++) mb[i] = ma[i];
    run_txn(3'd1, 8'h00, 1, 0, 0);
    vec++;
    if (tmo || gd.size() != 25) begin
      bad++;
      $display("FAIL sub_done got=%0d exp=25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      vec++;
      if (gd[i] !== 8'h00) begin
        bad++;
        $display("FAIL sub_zero%0d got=%h exp=00", i, gd[i]);
      end
    end
  endtask

  task automatic test_trans_scale();
    int r, c;
    fill_seq();
    run_txn(3'd3, 8'h00, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25) begin
      bad++;
      $display("FAIL trans_done got=%0d exp=25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      r = i / 5;
      c = i % 5;
      vec++;
      if (gd[i] !== 8'(c * 5 + r + 1)) begin
        bad++;
        $display("FAIL trans_beat%0d got=%0d exp=%0d",
          i, gd[i], c * 5 + r + 1);
      end
    end
    fill_rand();
    ma[0] = 8'd64;
    ma[1] = 8'hFF;
    model(3'd4, 8'hFE);
    run_txn(3'd4, 8'hFE, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25 || gd[0] !== 8'h80 ||
        gd[1] !== 8'h02) begin
      bad++;
      $display("FAIL scale_fixed got=%0d beats exp=25 80,02",
        gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      vec++;
      if (gd[i] !== ex[i]) begin
        bad++;
        $display("FAIL scale_beat%0d got=%h exp=%h", i, gd[i], ex[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] op;
    for (int k = 0; k < 6; k++) begin
      op = 3'($urandom_range(0, 4));
      fill_rand();
      cmd_scalar = 8'($urandom);
      model(op, cmd_scalar);
      run_txn(op, cmd_scalar, 1, 1, 0);
      vec++;
      if (tmo || gd.size() != 25 || stall_err != 0) begin
        bad++;
        $display("FAIL bp_run%0d got=%0d beats %0d unstable exp=25 0",
          k, gd.size(), stall_err);
      end
      for (int i = 0; i < gd.size(); i++) begin
        vec++;
        if (gd[i] !== ex[i] || gl[i] !== (i == 24)) begin
          bad++;
          $display("FAIL bp_op%0d_beat%0d got=%h/%b exp=%h/%b",
            op, i, gd[i], gl[i], ex[i], i == 24);
        end
      end
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_extra_beat got=%b exp=0", out_valid);
      end
    end
  endtask

  task automatic test_illegal();
    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    vec++;
    if (error !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL illegal_pulse got=%b%b%b exp=101",
        error, busy, cmd_ready);
    end
    @(negedge clk);
    vec++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal_clear got=%b%b exp=00", error, busy);
    end
    fill_rand();
    model(3'd2, 8'h00);
    run_txn(3'd2, 8'h00, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25) begin
      bad++;
      $display("FAIL illegal_next got=%0d exp=25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      vec++;
      if (gd[i] !== ex[i]) begin
        bad++;
        $display("FAIL illegal_next%0d got=%h exp=%h", i, gd[i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    run_txn(3'd2, 8'h00, 0, 0, 10);
    vec++;
    if (gd.size() != 10 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_reach got=%0d exp=10", gd.size());
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_async got=%b%b%b exp=000",
        out_valid, busy, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle got=%b%b exp=10", cmd_ready, out_valid);
    end
    fill_rand();
    model(3'd2, 8'h00);
    run_txn(3'd2, 8'h00, 0, 0, 0);
    vec++;
    if (tmo || gd.size() != 25) begin
      bad++;
      $display("FAIL rst_mid_rerun got=%0d exp=25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      vec++;
      if (gd[i] !== ex[i]) begin
        bad++;
        $display("FAIL rst_mid_beat%0d got=%h exp=%h", i, gd[i], ex[i]);
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_scalar = 8'h00;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_opp();
    test_add_sub();
    test_trans_scale();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
